// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: base opcodes, bubble encoding and
// the per-opcode decode of which source registers an instruction reads.
package rv_pkg;

  localparam logic [6:0]  OP        = 7'b0110011;
  localparam logic [6:0]  OP_32     = 7'b0111011;
  localparam logic [6:0]  STORE     = 7'b0100011;
  localparam logic [6:0]  BRANCH    = 7'b1100011;
  localparam logic [6:0]  LOAD      = 7'b0000011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_IMM_32 = 7'b0011011;
  localparam logic [6:0]  JALR      = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef struct packed {
    logic use1;
    logic use2;
  } src_use_t;

  // LUI, AUIPC, JAL, SYSTEM and anything unrecognised read no registers.
  function automatic src_use_t decode_src_use(input logic [6:0] opcode);
    src_use_t u;
    u = '0;
    case (opcode)
      OP, OP_32, STORE, BRANCH: begin
        u.use1 = 1'b1;
        u.use2 = 1'b1;
      end
      LOAD, OP_IMM, OP_IMM_32, JALR: u.use1 = 1'b1;
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads a register
// that the load currently in EX has not yet produced.
module hazard_detect
  import rv_pkg::*;
(
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  output logic        load_use
);

  src_use_t   src_use;
  logic [1:0] src_used;
  logic [1:0] src_match;
  logic [4:0] src_reg [2];
  logic       unused_instr_bits;

  assign src_use    = decode_src_use(id_instr[6:0]);
  assign src_used   = {src_use.use2, src_use.use1};
  assign src_reg[0] = id_instr[19:15];
  assign src_reg[1] = id_instr[24:20];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = src_used[gi] & (src_reg[gi] == ex_rd);
    end
  endgenerate

  // x0 is never really written, so a load targeting it cannot create a hazard.
  assign load_use = id_valid & ex_mem_read & (ex_rd != REG_ZERO) & (|src_match);

  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:7]};

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: holds PC/instruction for decode, stalls on
// load-use hazards, flushes on taken branches and counts stall cycles.
module if_id_stage
  import rv_pkg::*;
#(
  parameter int          XLEN      = 64,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic             pc_write,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  logic load_use;
  logic stall_take;

  hazard_detect u_hazard_detect (
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
  assign stall_take   = load_use & ~branch_taken;
  assign pc_write     = reset | ~stall_take;
  assign id_ex_bubble = ~reset & stall_take;

  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];
  assign id_rd  = id_instr[11:7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (branch_taken) begin
      id_pc    <= if_pc;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!load_use) begin
      id_pc    <= if_pc;
      id_instr <= if_instr;
      id_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_take && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
